if_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch stage with a decoupling fetch queue between

---
 rtl/if_fetch_queue_if.sv | 49 ++++
 rtl/if_fetch_queue.sv | 83 ++++++++
 tb/tb_if_fetch_queue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Fetch-queue handshake bundle: redirect from EX, imem request/response,
// and the {PC, NPC, IR} delivery channel towards decode.
interface if_fetch_queue_if #(
  parameter int XLEN = 32,
  parameter int CW   = 3
);
  logic            ex_take_branch_out;
  logic [XLEN-1:0] ex_target_PC_out;
  logic            imem_ready;
  logic [XLEN-1:0] Imem2proc_data;
  logic            id_ready;
  logic [XLEN-1:0] proc2Imem_addr;
  logic            proc2Imem_req;
  logic [XLEN-1:0] if_PC_out;
  logic [XLEN-1:0] if_NPC_out;
  logic [XLEN-1:0] if_IR_out;
  logic            if_valid_inst_out;
  logic [CW-1:0]   if_count;

  modport master (
    input  ex_take_branch_out,
    input  ex_target_PC_out,
    input  imem_ready,
    input  Imem2proc_data,
    input  id_ready,
    output proc2Imem_addr,
    output proc2Imem_req,
    output if_PC_out,
    output if_NPC_out,
    output if_IR_out,
    output if_valid_inst_out,
    output if_count
  );

  modport slave (
    output ex_take_branch_out,
    output ex_target_PC_out,
    output imem_ready,
    output Imem2proc_data,
    output id_ready,
    input  proc2Imem_addr,
    input  proc2Imem_req,
    input  if_PC_out,
    input  if_NPC_out,
    input  if_IR_out,
    input  if_valid_inst_out,
    input  if_count
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register plus a circular fetch queue
// decoupling imem from decode, flushed by taken branches from EX.
module if_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] PC_STEP  = 4
) (
  input logic clk,
  input logic rst_n,
  if_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] ir;
  } fq_entry_t;

  fq_entry_t       q [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic            redirect;
  logic            full;
  logic            valid;
  logic            deq;
  logic            req;
  logic            fetch;

  assign redirect = bus.ex_take_branch_out;
  assign full     = (count == CW'(DEPTH));
  assign valid    = (count != '0) & ~redirect;
  assign deq      = valid & bus.id_ready;
  // rst_n gates req so nothing is requested while held in reset
  assign req      = rst_n & ~redirect & (~full | deq);
  assign fetch    = req & bus.imem_ready;
  assign pc_next  = pc_reg + PC_STEP;

  assign bus.proc2Imem_addr    = {pc_reg[XLEN-1:2], 2'b00};
  assign bus.proc2Imem_req     = req;
  assign bus.if_PC_out         = q[head].pc;
  assign bus.if_NPC_out        = q[head].npc;
  assign bus.if_IR_out         = q[head].ir;
  assign bus.if_valid_inst_out = valid;
  assign bus.if_count          = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_PC;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else if (redirect) begin
      pc_reg <= bus.ex_target_PC_out & ~XLEN'(3);
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        q[tail] <= '{pc: pc_reg, npc: pc_next,
                     ir: bus.Imem2proc_data};
        tail    <= tail + 1'b1;
        pc_reg  <= pc_next;
      end
      if (deq) begin
        head <= head + 1'b1;
      end
      unique case (1'b1)
        fetch & ~deq: count <= count + 1'b1;
        deq & ~fetch: count <= count - 1'b1;
        default:      count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: imem modelled as addr+0x1000_0000,
// checks at #2 after each edge or #1 after input changes.
module tb_if_fetch_queue;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  if_fetch_queue_if #(.XLEN(32), .CW(3)) bus ();

  if_fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'h4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign bus.Imem2proc_data = bus.proc2Imem_addr + 32'h1000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.ex_take_branch_out = 1'b0;
    bus.ex_target_PC_out   = '0;
    bus.imem_ready         = 1'b1;
    bus.id_ready           = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.if_valid_inst_out), 32'd0);
    chk("rst_req",   32'(bus.proc2Imem_req), 32'd0);
    chk("rst_count", 32'(bus.if_count), 32'd0);
    chk("rst_pc",    bus.if_PC_out, 32'h0);
    chk("rst_ir",    bus.if_IR_out, 32'h0);
    chk("rst_addr",  bus.proc2Imem_addr, 32'h0);
    #7 rst_n = 1'b1;
    #1;
    chk("t1_req0",   32'(bus.proc2Imem_req), 32'd1);
    chk("t1_valid0", 32'(bus.if_valid_inst_out), 32'd0);
    // T1: streaming, one fetch and one deq per cycle
    edge_step();
    chk("t1_valid1", 32'(bus.if_valid_inst_out), 32'd1);
    chk("t1_pc1",    bus.if_PC_out, 32'h0);
    chk("t1_npc1",   bus.if_NPC_out, 32'h4);
    chk("t1_ir1",    bus.if_IR_out, 32'h1000_0000);
    chk("t1_addr1",  bus.proc2Imem_addr, 32'h4);
    chk("t1_cnt1",   32'(bus.if_count), 32'd1);
    edge_step();
    chk("t1_pc2",    bus.if_PC_out, 32'h4);
    chk("t1_cnt2",   32'(bus.if_count), 32'd1);
    edge_step();
    chk("t1_pc3",    bus.if_PC_out, 32'h8);
    chk("t1_ir3",    bus.if_IR_out, 32'h1000_0008);
    chk("t1_cnt3",   32'(bus.if_count), 32'd1);
    // T2: fill to full with decode stalled
    bus.ex_take_branch_out = 1'b1;
    bus.ex_target_PC_out   = 32'h0;
    edge_step();
    bus.ex_take_branch_out = 1'b0;
    bus.id_ready           = 1'b0;
    repeat (4) edge_step();
    chk("t2_cnt",    32'(bus.if_count), 32'd4);
    chk("t2_req",    32'(bus.proc2Imem_req), 32'd0);
    chk("t2_addr",   bus.proc2Imem_addr, 32'h10);
    chk("t2_pc",     bus.if_PC_out, 32'h0);
    edge_step();
    chk("t2_cnt_h",  32'(bus.if_count), 32'd4);
    chk("t2_addr_h", bus.proc2Imem_addr, 32'h10);
    bus.id_ready = 1'b1;
    #1;
    chk("t2_req_d",  32'(bus.proc2Imem_req), 32'd1);
    edge_step();
    chk("t2_cnt_d",  32'(bus.if_count), 32'd4);
    chk("t2_pc_d",   bus.if_PC_out, 32'h4);
    chk("t2_addr_d", bus.proc2Imem_addr, 32'h14);
    // T3: drain one, then redirect with count=3
    bus.imem_ready = 1'b0;
    edge_step();
    chk("t3_cnt3",   32'(bus.if_count), 32'd3);
    chk("t3_pc",     bus.if_PC_out, 32'h8);
    bus.imem_ready         = 1'b1;
    bus.ex_take_branch_out = 1'b1;
    bus.ex_target_PC_out   = 32'h103;
    #1;
    chk("t3_valid_br", 32'(bus.if_valid_inst_out), 32'd0);
    chk("t3_req_br",   32'(bus.proc2Imem_req), 32'd0);
    edge_step();
    bus.ex_take_branch_out = 1'b0;
    #1;
    chk("t3_cnt0",   32'(bus.if_count), 32'd0);
    chk("t3_valid0", 32'(bus.if_valid_inst_out), 32'd0);
    chk("t3_addr",   bus.proc2Imem_addr, 32'h100);
    edge_step();
    chk("t3_valid1", 32'(bus.if_valid_inst_out), 32'd1);
    chk("t3_pc1",    bus.if_PC_out, 32'h100);
    chk("t3_ir1",    bus.if_IR_out, 32'h1000_0100);
    edge_step();
    chk("t3_pc2",    bus.if_PC_out, 32'h104);
    // T4: imem_ready toggling
    bus.ex_take_branch_out = 1'b1;
    bus.ex_target_PC_out   = 32'h200;
    edge_step();
    bus.ex_take_branch_out = 1'b0;
    bus.imem_ready         = 1'b1;
    edge_step();
    bus.imem_ready = 1'b0;
    #1;
    chk("t4_valid_a", 32'(bus.if_valid_inst_out), 32'd1);
    chk("t4_pc_a",    bus.if_PC_out, 32'h200);
    edge_step();
    bus.imem_ready = 1'b1;
    #1;
    chk("t4_cnt_b",   32'(bus.if_count), 32'd0);
    chk("t4_valid_b", 32'(bus.if_valid_inst_out), 32'd0);
    chk("t4_addr_b",  bus.proc2Imem_addr, 32'h204);
    edge_step();
    bus.imem_ready = 1'b0;
    #1;
    chk("t4_pc_c",    bus.if_PC_out, 32'h204);
    chk("t4_cnt_c",   32'(bus.if_count), 32'd1);
    edge_step();
    chk("t4_cnt_d",   32'(bus.if_count), 32'd0);
    // T5: PC wrap
    bus.ex_take_branch_out = 1'b1;
    bus.ex_target_PC_out   = 32'hFFFF_FFFC;
    edge_step();
    bus.ex_take_branch_out = 1'b0;
    bus.imem_ready         = 1'b1;
    #1;
    chk("t5_addr0",  bus.proc2Imem_addr, 32'hFFFF_FFFC);
    edge_step();
    chk("t5_pc",     bus.if_PC_out, 32'hFFFF_FFFC);
    chk("t5_npc",    bus.if_NPC_out, 32'h0);
    chk("t5_ir",     bus.if_IR_out, 32'h0FFF_FFFC);
    chk("t5_addr1",  bus.proc2Imem_addr, 32'h0);
    // T6: asynchronous reset between edges
    edge_step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid",  32'(bus.if_valid_inst_out), 32'd0);
    chk("t6_count",  32'(bus.if_count), 32'd0);
    chk("t6_req",    32'(bus.proc2Imem_req), 32'd0);
    chk("t6_npc",    bus.if_NPC_out, 32'h0);
    chk("t6_addr",   bus.proc2Imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_step();
    chk("t6_valid1", 32'(bus.if_valid_inst_out), 32'd1);
    chk("t6_npc1",   bus.if_NPC_out, 32'h4);
    chk("t6_addr1",  bus.proc2Imem_addr, 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
